// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   Instruction-address generator for the SPORK fetch stage. A 16-bit PC is
//   cleared and launched by start. While running, it increments by one per
//   clock, takes signed relative jumps, and freezes on halt. Once halted, only
//   start or reset can move it again.
//
// Ports
//   clk        : system clock; all state updates happen on the rising edge
//   reset      : asynchronous, active-high; forces PC=RESET_VECTOR and IDLE
//   start      : level; loads RESET_VECTOR and enters RUN (highest sync prio)
//   halt       : level; in RUN, freezes PC and enters HALTED
//   jump       : level; in RUN, adds sign-extended jump_value to PC
//   jump_value : two's-complement branch offset, OFF_WIDTH bits
//   PC         : registered program counter, PC_WIDTH bits
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int unsigned                PC_WIDTH     = 16,
  parameter int unsigned                OFF_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0]        RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 jump,
  input  logic [OFF_WIDTH-1:0] jump_value,
  output logic [PC_WIDTH-1:0]  PC
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   offset_ext;

  // Replicate the offset's sign bit so that a negative offset wraps modulo
  // 2^PC_WIDTH in the addition below.
  assign offset_ext = {{(PC_WIDTH - OFF_WIDTH){jump_value[OFF_WIDTH-1]}}, jump_value};

  // Next-state logic. Priority below reset is start > halt > jump > increment.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;

    if (start) begin
      // Restart from any state. Counting begins on the first edge after
      // start drops.
      state_d = ST_RUN;
      pc_d    = RESET_VECTOR;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Wait for start; halt and jump are ignored.
        end
        ST_RUN: begin
          if (halt) begin
            // Any simultaneous jump is discarded.
            state_d = ST_HALTED;
          end else if (jump) begin
            pc_d = pc_q + offset_ext;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end
        ST_HALTED: begin
          // Sticky: deasserting halt does not resume execution.
        end
        default: begin
          state_d = ST_IDLE;
          pc_d    = RESET_VECTOR;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//   Bench for program_counter. The first part is a directed sequence with
//   hand-computed expected PC values. The second part is a randomized run.
//   A reference model works in plain integer arithmetic modulo 65536, and a
//   compare process checks PC against that model on every falling edge.
// -----------------------------------------------------------------------------
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        jump = 1'b0;
  logic [7:0]  jump_value = 8'h00;
  logic [15:0] PC;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model state: the PC as an integer, plus the operating mode.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  int m_pc   = 0;
  int m_mode = M_IDLE;

  program_counter #(
    .PC_WIDTH    (16),
    .OFF_WIDTH   (8),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt      (halt),
    .jump      (jump),
    .jump_value(jump_value),
    .PC        (PC)
  );

  // 10 ns clock; rising edges at 5, 15, 25 ns and so on.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: PC=0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  // Reference model, built from the behavioural rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc   = 0;
      m_mode = M_IDLE;
    end else if (start) begin
      m_pc   = 0;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (halt)      m_mode = M_HALT;
      else if (jump) m_pc = (m_pc + 65536 + (jump_value >= 8'd128 ? int'(jump_value) - 256
                                                                   : int'(jump_value))) % 65536;
      else           m_pc = (m_pc + 1) % 65536;
    end
  end

  // Compare process: check PC against the model on every falling edge.
  always @(negedge clk) begin
    check("model", PC, 16'(m_pc));
  end

  // Drive one cycle's inputs just after the falling edge, then wait until just
  // after the next rising edge.
  task automatic cyc(input logic s, input logic h, input logic j, input logic [7:0] v);
    @(negedge clk);
    #1;
    start = s; halt = h; jump = j; jump_value = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", PC, 16'h0000);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // In IDLE, PC holds at 0 even with halt or jump asserted.
    cyc(0, 0, 0, 8'h00);  check("idle_hold", PC, 16'h0000);
    cyc(0, 0, 1, 8'h05);  check("idle_ignores_jump", PC, 16'h0000);

    // Two start cycles keep PC at 0; counting begins once start drops.
    cyc(1, 0, 0, 8'h00);  check("start_edge1", PC, 16'h0000);
    cyc(1, 0, 0, 8'h00);  check("start_edge2", PC, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 8'h00);
      check("count", PC, 16'(i));
    end

    // Forward jump of +2, then counting continues to 12.
    cyc(0, 0, 1, 8'h02);  check("fwd_jump", PC, 16'd7);
    for (int i = 8; i <= 12; i++) begin
      cyc(0, 0, 0, 8'h00);
      check("count_after_jump", PC, 16'(i));
    end

    // Halt is sticky: PC stays frozen after halt drops and ignores a jump.
    cyc(0, 1, 0, 8'h00);  check("halt", PC, 16'd12);
    cyc(0, 0, 0, 8'h00);  check("halt_sticky", PC, 16'd12);
    cyc(0, 0, 1, 8'h10);  check("halt_ignores_jump", PC, 16'd12);
    cyc(1, 0, 0, 8'h00);  check("restart", PC, 16'd0);
    cyc(0, 0, 0, 8'h00);  check("resume", PC, 16'd1);

    // A backward jump wraps below zero; the next increment wraps back to 0.
    cyc(0, 0, 1, 8'hFE);  check("back_jump_wrap", PC, 16'hFFFF);
    cyc(0, 0, 0, 8'h00);  check("inc_wrap", PC, 16'h0000);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 8'h00);
    check("count_to_5", PC, 16'h0005);
    cyc(0, 0, 1, 8'h80);  check("jump_minus128", PC, 16'hFF85);
    cyc(0, 0, 1, 8'h00);  check("jump_zero_holds", PC, 16'hFF85);

    // When halt and jump arrive together, halt wins and the state becomes HALTED.
    cyc(0, 1, 1, 8'h03);  check("halt_beats_jump", PC, 16'hFF85);
    cyc(0, 0, 0, 8'h00);  check("halted_after_tie", PC, 16'hFF85);

    // When start and halt arrive together, start wins.
    cyc(1, 1, 0, 8'h00);  check("start_beats_halt", PC, 16'h0000);
    cyc(0, 0, 0, 8'h00);  check("run_after_start", PC, 16'h0001);
    cyc(0, 0, 0, 8'h00);  check("run_after_start2", PC, 16'h0002);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", PC, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held", PC, 16'h0000);
    @(negedge clk);
    #1;
    reset = 1'b0;
    cyc(0, 0, 0, 8'h00);  check("idle_after_reset", PC, 16'h0000);

    // Randomized run, checked by the compare process against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      reset      = ($urandom_range(0, 127) == 0);
      start      = ($urandom_range(0, 15) == 0);
      halt       = ($urandom_range(0, 19) == 0);
      jump       = ($urandom_range(0, 3) == 0);
      jump_value = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    #1;
    reset = 1'b0; start = 1'b0; halt = 1'b0; jump = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
